// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//
// Purpose : Bundles every bus signal around mem_arbiter: the instruction-fetch
//           port (m0_*), the load/store port (m1_*), the shared mem_ctrl
//           request port (mc_*) and the sticky watchdog flag.
//
// Modports:
//   slave  - the arbiter itself. It serves the two CPU ports, drives the
//            mem_ctrl request and reports timeouts.
//   master - the surrounding system (CPU ports plus mem_ctrl). It drives the
//            requests and the memory responses.
//
// Signals (direction as seen by the arbiter):
//   m0_rd, m0_wr      in   fetch-port read/write request (level)
//   m0_addr[31:0]     in   fetch-port byte address
//   m0_data_i[31:0]   in   fetch-port write data
//   m0_data_o[31:0]   out  fetch-port read data
//   m0_hold           out  stall to the fetch port
//   m1_*              same set of signals for the load/store port
//   mc_rd, mc_wr      out  request to mem_ctrl
//   mc_addr[31:0]     out  address to mem_ctrl
//   mc_data_o[31:0]   out  write data to mem_ctrl
//   mc_data_i[31:0]   in   read data from mem_ctrl
//   mc_hold           in   mem_ctrl hold_cpu
//   timeout_err       out  sticky watchdog-abort flag
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    logic        m0_rd;
    logic        m0_wr;
    logic [31:0] m0_addr;
    logic [31:0] m0_data_i;
    logic [31:0] m0_data_o;
    logic        m0_hold;

    logic        m1_rd;
    logic        m1_wr;
    logic [31:0] m1_addr;
    logic [31:0] m1_data_i;
    logic [31:0] m1_data_o;
    logic        m1_hold;

    logic        mc_rd;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [31:0] mc_data_o;
    logic [31:0] mc_data_i;
    logic        mc_hold;

    logic        timeout_err;

    modport slave (
        input  m0_rd, m0_wr, m0_addr, m0_data_i,
        output m0_data_o, m0_hold,
        input  m1_rd, m1_wr, m1_addr, m1_data_i,
        output m1_data_o, m1_hold,
        output mc_rd, mc_wr, mc_addr, mc_data_o,
        input  mc_data_i, mc_hold,
        output timeout_err
    );

    modport master (
        output m0_rd, m0_wr, m0_addr, m0_data_i,
        input  m0_data_o, m0_hold,
        output m1_rd, m1_wr, m1_addr, m1_data_i,
        input  m1_data_o, m1_hold,
        input  mc_rd, mc_wr, mc_addr, mc_data_o,
        output mc_data_i, mc_hold,
        input  timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose : Shares the single mem_ctrl request port between the fetch port
//           (M0) and the load/store port (M1). Each access runs through
//           IDLE -> BUSY (wait while mc_hold) -> RESP (one-cycle data return)
//           -> IDLE. A watchdog aborts an access that stays on hold for
//           TIMEOUT BUSY cycles, returns zero data and sets a sticky error.
//
// Ports   : clk  - system clock, rising edge
//           rst  - synchronous, active-high reset
//           bus  - mem_arbiter_if.slave (M0, M1, mem_ctrl and timeout_err)
//
// Parameter: TIMEOUT (0..255, default 255) - BUSY cycles on hold before abort;
//            0 disables the watchdog.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to break ties between the two
//               masters round-robin (the master other than the last one
//               granted wins; first tie after reset goes to M0). Without it,
//               M1 always wins ties.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam bit         WDOG_EN   = (TIMEOUT != 0);
    localparam logic [7:0] WDOG_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_e      state_q;
    logic        grant_q;        // 0 = M0, 1 = M1
    logic        last_grant_q;
    logic [7:0]  wdog_q;
    logic        abort_q;        // current access was ended by the watchdog
    logic        timeout_err_q;
    logic [31:0] rdata_q [2];

    logic        req0;
    logic        req1;
    logic        tie_grant;
    logic [31:0] resp_data;

    // A master requests only when exactly one of rd/wr is high.
    assign req0 = bus.m0_rd ^ bus.m0_wr;
    assign req1 = bus.m1_rd ^ bus.m1_wr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie_grant = ~last_grant_q;
`else
    // Fixed priority to M1; last_grant_q is folded in only so it stays read.
    assign tie_grant = last_grant_q | 1'b1;
`endif

    // Word returned to the granted master in RESP.
    assign resp_data = abort_q ? 32'h0 : bus.mc_data_i;

    always_ff @(posedge clk) begin
        // NOTE: every state register uses <= so all of them update from the
        // same pre-edge values, independent of statement order.
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            wdog_q        <= 8'd0;
            abort_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            // NOTE: rdata_q is two words whose contents are visible on the
            // data_o ports, so it is reset like ordinary flops rather than
            // left uninitialised like a RAM.
            rdata_q[0]    <= 32'h0;
            rdata_q[1]    <= 32'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_q <= (req0 && req1) ? tie_grant : req1;
                        wdog_q  <= 8'd0;
                        abort_q <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!bus.mc_hold) begin
                        state_q <= RESP;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                        if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
                            timeout_err_q <= 1'b1;
                            abort_q       <= 1'b1;
                            state_q       <= RESP;
                        end
                    end
                end
                RESP: begin
                    rdata_q[grant_q] <= resp_data;
                    last_grant_q     <= grant_q;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Address and write data always follow the granted master; only the
    // rd/wr strobes are qualified by BUSY.
    assign bus.mc_addr   = grant_q ? bus.m1_addr   : bus.m0_addr;
    assign bus.mc_data_o = grant_q ? bus.m1_data_i : bus.m0_data_i;

    always_comb begin
        // NOTE: defaults first so every path assigns both strobes; without
        // them a missing branch would infer a latch.
        bus.mc_rd = 1'b0;
        bus.mc_wr = 1'b0;
        if (state_q == BUSY) begin
            bus.mc_rd = grant_q ? bus.m1_rd : bus.m0_rd;
            bus.mc_wr = grant_q ? bus.m1_wr : bus.m0_wr;
        end
    end

    logic resp0;
    logic resp1;

    assign resp0 = (state_q == RESP) && !grant_q;
    assign resp1 = (state_q == RESP) &&  grant_q;

    // A requester stays stalled until its own RESP cycle.
    assign bus.m0_hold = req0 && !resp0;
    assign bus.m1_hold = req1 && !resp1;

    assign bus.m0_data_o = resp0 ? resp_data : rdata_q[0];
    assign bus.m1_data_o = resp1 ? resp_data : rdata_q[1];

    assign bus.timeout_err = timeout_err_q;

endmodule
